// File: rtl/mandel_iter_ctrl.sv
// -----------------------------------------------------------------------------
// mandel_iter_ctrl
//
// Sequencer for a two-stage Mandelbrot iteration datapath. The module walks a
// frame pixel by pixel in raster order (x fastest). For each pixel it runs:
//   INIT, then (STAGE1, STAGE2, CHECK) repeated until escape or the limit,
//   then EMIT.
// It presents one result per pixel on a valid/ready output port.
//
// Handshake: out_valid is high only in EMIT. A result transfers on a rising
// edge where out_valid && out_ready. While out_valid is high and out_ready is
// low, out_x/out_y/out_iter are held and the sequencer stalls. out_valid
// never drops before the transfer.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                begin a frame (only looked at in IDLE)
//   max_iter             iteration limit, latched on start (0 means 1)
//   escaped              datapath escape flag (only looked at in CHECK)
//   out_ready            downstream accepts a result
//   init                 datapath: load c / clear z for the current pixel
//   en_stage_1           datapath: advance pipeline stage 1
//   en_stage_2           datapath: advance pipeline stage 2
//   out_valid            result available
//   out_x, out_y         pixel coordinate of the result
//   out_iter             iteration count of the result
//   busy                 high whenever the sequencer is not IDLE
//   frame_done           one-cycle pulse after the last pixel's transfer
//   state_dbg            current FSM state encoding, for debug/checkers
// -----------------------------------------------------------------------------
module mandel_iter_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ITER_W = 8,
  parameter int X_W    = $clog2(H_RES),
  parameter int Y_W    = $clog2(V_RES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              escaped,
  input  logic              out_ready,
  output logic              init,
  output logic              en_stage_1,
  output logic              en_stage_2,
  output logic              out_valid,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic [ITER_W-1:0] out_iter,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_STAGE1 = 3'd2,
    S_STAGE2 = 3'd3,
    S_CHECK  = 3'd4,
    S_EMIT   = 3'd5
  } state_t;

  localparam logic [X_W-1:0]    X_LAST   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_RES - 1);
  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

  state_t              state;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [ITER_W-1:0]   iter_cnt;
  logic [ITER_W-1:0]   lim;
  logic [X_W-1:0]      out_x_r;
  logic [Y_W-1:0]      out_y_r;
  logic [ITER_W-1:0]   out_iter_r;
  logic                frame_done_r;

  logic handshake;
  logic last_x;
  logic last_y;

  assign handshake = (state == S_EMIT) && out_ready;
  assign last_x    = (x == X_LAST);
  assign last_y    = (y == Y_LAST);

  // ---------------------------------------------------------------------------
  // Sequencer. All state, counters and result registers live here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      x            <= '0;
      y            <= '0;
      iter_cnt     <= '0;
      lim          <= '0;
      out_x_r      <= '0;
      out_y_r      <= '0;
      out_iter_r   <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // A limit of zero would never let CHECK terminate on count alone
            // before wrapping, so it is promoted to one iteration.
            lim   <= (max_iter == '0) ? ITER_ONE : max_iter;
            x     <= '0;
            y     <= '0;
            state <= S_INIT;
          end
        end

        S_INIT: begin
          iter_cnt <= '0;
          state    <= S_STAGE1;
        end

        S_STAGE1: begin
          state <= S_STAGE2;
        end

        S_STAGE2: begin
          iter_cnt <= iter_cnt + ITER_ONE;
          state    <= S_CHECK;
        end

        S_CHECK: begin
          // lim >= 1 and iter_cnt climbs by one per pass, so equality is
          // always reached before iter_cnt could pass lim or wrap.
          if (escaped || (iter_cnt == lim)) begin
            out_x_r    <= x;
            out_y_r    <= y;
            out_iter_r <= iter_cnt;
            state      <= S_EMIT;
          end else begin
            state <= S_STAGE1;
          end
        end

        S_EMIT: begin
          if (handshake) begin
            if (last_x && last_y) begin
              frame_done_r <= 1'b1;
              state        <= S_IDLE;
            end else if (last_x) begin
              x     <= '0;
              y     <= y + Y_W'(1);
              state <= S_INIT;
            end else begin
              x     <= x + X_W'(1);
              state <= S_INIT;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs: decoded from the registered state only, so no input can
  // reach an output combinationally. The state decode makes the three
  // datapath enables mutually exclusive by construction.
  // ---------------------------------------------------------------------------
  assign init       = (state == S_INIT);
  assign en_stage_1 = (state == S_STAGE1);
  assign en_stage_2 = (state == S_STAGE2);
  assign out_valid  = (state == S_EMIT);
  assign busy       = (state != S_IDLE);
  assign frame_done = frame_done_r;

  // Result registers are loaded only on entry to EMIT, so they read zero
  // from reset until the first result and then keep the last result.
  assign out_x      = out_x_r;
  assign out_y      = out_y_r;
  assign out_iter   = out_iter_r;

  assign state_dbg  = state;

  // ---------------------------------------------------------------------------
  // Embedded properties
  // ---------------------------------------------------------------------------
  enables_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0({init, en_stage_1, en_stage_2}));

  iter_within_lim : assert property (@(posedge clk) disable iff (rst)
    (state != S_IDLE) |-> (iter_cnt <= lim));

  result_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_x) && $stable(out_y) && $stable(out_iter)));

endmodule
